// File: rtl/cpu_seq_pkg.sv
// Shared definitions for cpu_sequencer: state encodings, default parameters,
// control-strobe bus layout and a byte parity helper.
package cpu_seq_pkg;

  localparam int PC_W_DEF     = 8;
  localparam int WAIT_MAX_DEF = 15;
  localparam int WAIT_CNT_W   = 8;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH_I   = 4'd1,
    ST_FETCH_IMM = 4'd2,
    ST_DECODE    = 4'd3,
    ST_EXECUTE   = 4'd4,
    ST_WRITEBACK = 4'd5,
    ST_OUTPUT    = 4'd6,
    ST_HALT      = 4'd7,
    ST_FAULT     = 4'd8,
    ST_PAUSE     = 4'd9
  } seq_state_e;

  // Bit positions of the phase strobes inside the packed control bus
  localparam int STB_INS  = 0;
  localparam int STB_IMM  = 1;
  localparam int STB_EXEC = 2;
  localparam int STB_WB   = 3;
  localparam int STB_OUT  = 4;
  localparam int STB_W    = 5;

  function automatic logic parity8(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Fetch wait counter for cpu_sequencer: clears on request, counts idle fetch
// cycles and flags the last permitted cycle (count == WAIT_MAX-1).
module seq_wait_timer
  import cpu_seq_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam logic [WAIT_CNT_W-1:0] LAST_CNT = WAIT_CNT_W'(WAIT_MAX - 1);
  localparam logic [WAIT_CNT_W-1:0] CNT_ONE  = WAIT_CNT_W'(1'b1);

  logic [WAIT_CNT_W-1:0] count_r;

  // Wait counter register; clear has priority over increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= {WAIT_CNT_W{1'b0}};
    end else if (clr) begin
      count_r <= {WAIT_CNT_W{1'b0}};
    end else if (inc) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = (count_r == LAST_CNT);

endmodule

// File: rtl/cpu_sequencer.sv
// Phase sequencer for the 8-bit CPU: host byte fetch, PC ownership, phase strobes,
// halt/fault detection. Optional single-step PAUSE state under CPU_SEQ_STEP_EN.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int PC_W     = PC_W_DEF,
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
`ifdef CPU_SEQ_STEP_EN
  input  logic            step,
`endif
  input  logic [7:0]      byte_in,
  input  logic            byte_valid,
  output logic            byte_req,
  input  logic            needs_imm,
  input  logic            is_halt,
  input  logic            is_jump,
  input  logic [PC_W-1:0] jmp_addr,
  output logic [PC_W-1:0] pc,
  output logic            ins_load,
  output logic            imm_load,
  output logic            exec_en,
  output logic            wb_en,
  output logic            out_en,
  output logic [3:0]      state,
  output logic            halted,
  output logic            fault
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1'b1);

  seq_state_e       state_r;
  seq_state_e       state_nxt_s;
  logic [PC_W-1:0]  pc_r;
  logic [PC_W-1:0]  pc_nxt_s;
  logic [STB_W-1:0] stb_s;
  logic             req_s;
  logic             tmr_clr_s;
  logic             tmr_inc_s;
  logic             tmr_expire_s;
  logic             unused_byte_s;

  // The data byte goes straight to the instruction/immediate registers
  assign unused_byte_s = parity8(byte_in);

  seq_wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr_s),
    .inc    (tmr_inc_s),
    .expire (tmr_expire_s)
  );

  // Next-state, PC update and phase strobe decode
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    stb_s       = {STB_W{1'b0}};
    req_s       = 1'b0;
    tmr_clr_s   = 1'b1;
    tmr_inc_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (run) begin
          state_nxt_s = ST_FETCH_I;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH_I, ST_FETCH_IMM: begin
        req_s = 1'b1;
        if (byte_valid) begin
          pc_nxt_s = pc_r + PC_ONE;
          if (state_r == ST_FETCH_I) begin
            stb_s[STB_INS] = 1'b1;
            state_nxt_s    = ST_DECODE;
          end else begin
            stb_s[STB_IMM] = 1'b1;
            state_nxt_s    = ST_EXECUTE;
          end
        end else begin
          tmr_clr_s = 1'b0;
          tmr_inc_s = 1'b1;
          // A valid on the last permitted cycle takes the branch above instead
          if (tmr_expire_s) begin
            state_nxt_s = ST_FAULT;
          end else begin
            state_nxt_s = state_r;
          end
        end
      end
      ST_DECODE: begin
        if (is_halt) begin
          state_nxt_s = ST_HALT;
        end else if (needs_imm) begin
          state_nxt_s = ST_FETCH_IMM;
        end else begin
          state_nxt_s = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        stb_s[STB_EXEC] = 1'b1;
        state_nxt_s     = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        stb_s[STB_WB] = 1'b1;
        state_nxt_s   = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        stb_s[STB_OUT] = 1'b1;
        if (is_jump) begin
          pc_nxt_s = jmp_addr;
        end else begin
          pc_nxt_s = pc_r;
        end
        if (run) begin
`ifdef CPU_SEQ_STEP_EN
          state_nxt_s = ST_PAUSE;
`else
          state_nxt_s = ST_FETCH_I;
`endif
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
`ifdef CPU_SEQ_STEP_EN
      ST_PAUSE: begin
        if (!run) begin
          state_nxt_s = ST_IDLE;
        end else if (step) begin
          state_nxt_s = ST_FETCH_I;
        end else begin
          state_nxt_s = ST_PAUSE;
        end
      end
`endif
      ST_HALT, ST_FAULT: begin
        state_nxt_s = state_r;
      end
      default: begin
        // Unreachable encodings are treated as a fault
        state_nxt_s = ST_FAULT;
      end
    endcase
  end

  // State and program counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      pc_r    <= {PC_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
    end
  end

  // Gated by rst_n so a fetch in flight during reset is never accepted
  assign byte_req = rst_n & req_s;
  assign ins_load = rst_n & stb_s[STB_INS];
  assign imm_load = rst_n & stb_s[STB_IMM];
  assign exec_en  = rst_n & stb_s[STB_EXEC];
  assign wb_en    = rst_n & stb_s[STB_WB];
  assign out_en   = rst_n & stb_s[STB_OUT];

  assign pc     = pc_r;
  assign state  = state_r;
  assign halted = (state_r == ST_HALT);
  assign fault  = (state_r == ST_FAULT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: randomized instruction stream checked
// cycle by cycle against an instruction-level model of the phase sequence.
module tb_cpu_sequencer;

  localparam int WAIT_MAX = 15;

  localparam logic [7:0] X_NONE = 8'h00;
  localparam logic [7:0] X_REQ  = 8'h80;
  localparam logic [7:0] X_INS  = 8'h40;
  localparam logic [7:0] X_IMM  = 8'h20;
  localparam logic [7:0] X_EXE  = 8'h10;
  localparam logic [7:0] X_WB   = 8'h08;
  localparam logic [7:0] X_OUT  = 8'h04;
  localparam logic [7:0] X_HALT = 8'h02;
  localparam logic [7:0] X_FLT  = 8'h01;

  logic       clk = 1'b0;
  logic       rst_n, run, byte_valid, needs_imm, is_halt, is_jump;
  logic [7:0] byte_in, jmp_addr, pc;
  logic       byte_req, ins_load, imm_load, exec_en, wb_en, out_en, halted, fault;
  logic [3:0] state;
`ifdef CPU_SEQ_STEP_EN
  logic       step;
  bit         m_pause;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int m_pc;
  bit m_idle;

  always #5 clk = ~clk;

  cpu_sequencer #(.PC_W(8), .WAIT_MAX(WAIT_MAX)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
`ifdef CPU_SEQ_STEP_EN
    .step       (step),
`endif
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_req   (byte_req),
    .needs_imm  (needs_imm),
    .is_halt    (is_halt),
    .is_jump    (is_jump),
    .jmp_addr   (jmp_addr),
    .pc         (pc),
    .ins_load   (ins_load),
    .imm_load   (imm_load),
    .exec_en    (exec_en),
    .wb_en      (wb_en),
    .out_en     (out_en),
    .state      (state),
    .halted     (halted),
    .fault      (fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic noise();
    byte_in    = 8'($urandom);
    byte_valid = 1'($urandom);
    needs_imm  = 1'($urandom);
    is_halt    = 1'($urandom);
    is_jump    = 1'($urandom);
    jmp_addr   = 8'($urandom);
    run        = 1'($urandom);
`ifdef CPU_SEQ_STEP_EN
    step       = 1'($urandom);
`endif
  endtask

  // Inputs already driven at posedge+1; check at posedge+2, return at next posedge+1
  task automatic cyc(input string tag, input logic [7:0] exp_flags);
    #1;
    check(tag, {16'd0, byte_req, ins_load, imm_load, exec_en, wb_en, out_en, halted, fault, pc},
          {16'd0, exp_flags, m_pc[7:0]});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    noise();
    rst_n = 1'b0;
    byte_valid = 1'b1;
    #1;
    check("rst_gate", {29'd0, byte_req, ins_load, imm_load}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run = 1'b0;
    byte_valid = 1'b0;
    #1;
    check("reset", {12'd0, state, byte_req, ins_load, imm_load, exec_en, wb_en, out_en, halted, fault, pc},
          32'd0);
    @(posedge clk);
    #1;
    m_pc = 0;
    m_idle = 1'b1;
`ifdef CPU_SEQ_STEP_EN
    m_pause = 1'b0;
`endif
  endtask

  // Bring the model/DUT from IDLE or PAUSE to the start of an instruction fetch
  task automatic enter_fetch();
`ifdef CPU_SEQ_STEP_EN
    if (m_pause) begin
      repeat ($urandom_range(0, 3)) begin
        noise(); run = 1'b1; step = 1'b0; cyc("pause", X_NONE);
      end
      if ($urandom_range(0, 3) == 0) begin
        noise(); run = 1'b0; cyc("pause_quit", X_NONE);
        m_idle = 1'b1;
      end else begin
        noise(); run = 1'b1; step = 1'b1; cyc("pause_go", X_NONE);
      end
      m_pause = 1'b0;
    end
`endif
    if (m_idle) begin
      noise(); run = 1'b1; cyc("idle", X_NONE);
      m_idle = 1'b0;
    end
  endtask

  task automatic fetch(input int waits, input bit imm, input string tag);
    for (int w = 0; w < waits; w++) begin
      noise(); byte_valid = 1'b0; cyc({tag, "_wait"}, X_REQ);
    end
    noise(); byte_valid = 1'b1; cyc(tag, X_REQ | (imm ? X_IMM : X_INS));
    m_pc = (m_pc + 1) % 256;
  endtask

  task automatic instr(input int wi, input int wm, input bit imm, input bit jmp,
                       input logic [7:0] ja, input bit run_after);
    enter_fetch();
    fetch(wi, 1'b0, "fetch_i");
    noise(); is_halt = 1'b0; needs_imm = imm; cyc("decode", X_NONE);
    if (imm) fetch(wm, 1'b1, "fetch_imm");
    noise(); cyc("exec", X_EXE);
    noise(); cyc("wb", X_WB);
    noise(); is_jump = jmp; jmp_addr = ja; run = run_after; cyc("out", X_OUT);
    if (jmp) m_pc = ja;
    if (!run_after) m_idle = 1'b1;
`ifdef CPU_SEQ_STEP_EN
    else m_pause = 1'b1;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    noise();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Directed: plain, immediate, jump, wrap, wait boundary
    instr(0, 0, 1'b0, 1'b0, 8'h00, 1'b1);
    instr(0, 0, 1'b1, 1'b0, 8'h00, 1'b1);
    instr(0, 0, 1'b1, 1'b1, 8'h40, 1'b1);
    instr(0, 0, 1'b0, 1'b0, 8'h00, 1'b0);
    instr(0, 0, 1'b1, 1'b1, 8'hFF, 1'b1);
    instr(0, 0, 1'b0, 1'b0, 8'h00, 1'b1);
    instr(WAIT_MAX - 1, WAIT_MAX - 1, 1'b1, 1'b0, 8'h00, 1'b1);

    // Randomized instruction stream
    for (int i = 0; i < 40; i++) begin
      instr($urandom_range(0, WAIT_MAX - 1), $urandom_range(0, WAIT_MAX - 1),
            1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
    end

    // Timeout in FETCH_I
    enter_fetch();
    repeat (WAIT_MAX) begin
      noise(); byte_valid = 1'b0; cyc("fi_timeout", X_REQ);
    end
    repeat (5) begin
      noise(); cyc("fault_i", X_FLT);
    end
    do_reset();

    // Timeout in FETCH_IMM
    enter_fetch();
    fetch(2, 1'b0, "fetch_i");
    noise(); is_halt = 1'b0; needs_imm = 1'b1; cyc("decode", X_NONE);
    repeat (WAIT_MAX) begin
      noise(); byte_valid = 1'b0; cyc("fm_timeout", X_REQ);
    end
    repeat (5) begin
      noise(); cyc("fault_imm", X_FLT);
    end
    do_reset();

    // HALT is sticky with PC frozen
    instr(1, 0, 1'b0, 1'b1, 8'h80, 1'b1);
    enter_fetch();
    fetch($urandom_range(0, 3), 1'b0, "fetch_i");
    noise(); is_halt = 1'b1; cyc("decode_halt", X_NONE);
    repeat (20) begin
      noise(); cyc("halt", X_HALT);
    end
    do_reset();

    // Reset while an immediate byte is on offer
    instr(0, 0, 1'b0, 1'b0, 8'h00, 1'b1);
    enter_fetch();
    fetch(0, 1'b0, "fetch_i");
    noise(); is_halt = 1'b0; needs_imm = 1'b1; cyc("decode", X_NONE);
    do_reset();
    instr(0, 0, 1'b0, 1'b0, 8'h00, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
